// File: rtl/pl_mem_wb.sv
// Memory/write-back stage: data-memory access over a req/ack handshake,
// integer/RNS register-file write-back and the architectural carry flag.

module pl_mem_wb_lane #(
    parameter int LANE = 0
) (
    input  logic [7:0] src,
    input  logic       rns,
    output logic [7:0] data
);
    // Integer writes only carry lane 0; RNS writes carry every residue lane.
    assign data = (rns || LANE == 0) ? src : 8'h00;
endmodule

module pl_mem_wb #(
    parameter int NUM_DOMAINS = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [0:6]               EX_reg,
    input  logic [8*NUM_DOMAINS-1:0] operation_result,
    input  logic [15:0]              data_wr_addr,
    input  logic [15:0]              data_rd_addr,
    input  logic [2:0]               destination_reg_addr,
    input  logic                     destination_RNS,
    input  logic [0:4]               branch_conds_EX,
    input  logic                     mem_ack,
    input  logic [8*NUM_DOMAINS-1:0] mem_rdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [15:0]              mem_addr,
    output logic [8*NUM_DOMAINS-1:0] mem_wdata,
    output logic                     stall,
    output logic                     rf_wr_en,
    output logic                     rns_rf_wr_en,
    output logic [2:0]               rf_wr_addr,
    output logic [8*NUM_DOMAINS-1:0] rf_wr_data,
    output logic                     carry_flag,
    output logic                     mem_fault
);
    localparam int W  = 8 * NUM_DOMAINS;
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WB} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt;
    logic [2:0]            lat_dest;
    logic                  lat_rns;
    logic                  ex_store, ex_wr, ex_cout, ex_load, valid;
    logic                  mem_op, alu_wr, timeout;
    logic [W-1:0]          wr_src, wr_data;
    logic                  wr_rns;
    logic [NUM_DOMAINS-1:0][7:0] wr_lanes;
    logic                  unused_ok;

    assign ex_store = EX_reg[0];
    assign ex_wr    = EX_reg[1];
    assign ex_cout  = EX_reg[2];
    assign valid    = !EX_reg[3];
    assign ex_load  = EX_reg[4];
    assign unused_ok = ^{EX_reg[5:6], branch_conds_EX[0:2], branch_conds_EX[4]};

    assign mem_op  = valid && (ex_store || ex_load);
    assign alu_wr  = valid && ex_wr && !ex_load;
    assign timeout = (MEM_TIMEOUT != 0) && (int'(cnt) == MEM_TIMEOUT - 1);

    // One shared write datapath: load data in REQ, EX result in IDLE.
    assign wr_src = (state == REQ) ? mem_rdata : operation_result;
    assign wr_rns = (state == REQ) ? lat_rns   : destination_RNS;

    for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_lane
        pl_mem_wb_lane #(.LANE(i)) u_lane (
            .src  (wr_src[8*i +: 8]),
            .rns  (wr_rns),
            .data (wr_lanes[i])
        );
    end
    assign wr_data = wr_lanes;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mem_op) state_nxt = REQ;
            REQ: begin
                if (mem_ack)      state_nxt = mem_we ? IDLE : WB;
                else if (timeout) state_nxt = IDLE;
            end
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign stall = (state != IDLE) || mem_op;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            lat_dest     <= '0;
            lat_rns      <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            rf_wr_en     <= 1'b0;
            rns_rf_wr_en <= 1'b0;
            rf_wr_addr   <= '0;
            rf_wr_data   <= '0;
            carry_flag   <= 1'b0;
            mem_fault    <= 1'b0;
        end else begin
            state        <= state_nxt;
            rf_wr_en     <= 1'b0;
            rns_rf_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid && ex_cout) carry_flag <= branch_conds_EX[3];
                    if (mem_op) begin
                        mem_req   <= 1'b1;
                        mem_we    <= ex_store;
                        mem_addr  <= ex_store ? data_wr_addr : data_rd_addr;
                        mem_wdata <= operation_result;
                        lat_dest  <= destination_reg_addr;
                        lat_rns   <= destination_RNS;
                        cnt       <= '0;
                    end
                    if (alu_wr) begin
                        rf_wr_en     <= !destination_RNS;
                        rns_rf_wr_en <= destination_RNS;
                        rf_wr_addr   <= destination_reg_addr;
                        rf_wr_data   <= wr_data;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            rf_wr_en     <= !lat_rns;
                            rns_rf_wr_en <= lat_rns;
                            rf_wr_addr   <= lat_dest;
                            rf_wr_data   <= wr_data;
                        end
                    end else if (timeout) begin
                        mem_req   <= 1'b0;
                        mem_fault <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pl_mem_wb.sv
// Directed + randomized bench for pl_mem_wb (2 RNS lanes, timeout 15)
// against a transaction-level model of expected bus/regfile behaviour.

module tb_pl_mem_wb;
    localparam int ND = 2;
    localparam int W  = 8 * ND;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [0:6]    EX_reg;
    logic [W-1:0]  operation_result;
    logic [15:0]   data_wr_addr, data_rd_addr;
    logic [2:0]    destination_reg_addr;
    logic          destination_RNS;
    logic [0:4]    branch_conds_EX;
    logic          mem_ack;
    logic [W-1:0]  mem_rdata;
    logic          mem_req, mem_we, stall, rf_wr_en, rns_rf_wr_en, carry_flag, mem_fault;
    logic [15:0]   mem_addr;
    logic [W-1:0]  mem_wdata, rf_wr_data;
    logic [2:0]    rf_wr_addr;

    int   n_cmp = 0;
    int   n_err = 0;
    logic carry_m = 1'b0;
    logic fault_m = 1'b0;

    pl_mem_wb #(.NUM_DOMAINS(ND), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .EX_reg(EX_reg), .operation_result(operation_result),
        .data_wr_addr(data_wr_addr), .data_rd_addr(data_rd_addr),
        .destination_reg_addr(destination_reg_addr), .destination_RNS(destination_RNS),
        .branch_conds_EX(branch_conds_EX), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .stall(stall), .rf_wr_en(rf_wr_en), .rns_rf_wr_en(rns_rf_wr_en),
        .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .carry_flag(carry_flag),
        .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:6] exw(input bit st, input bit wr, input bit cout,
                                       input bit inv, input bit ld);
        return {st, wr, cout, inv, ld, 2'b00};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bc(input bit cin);
        branch_conds_EX    = 5'($urandom);
        branch_conds_EX[3] = cin;
    endtask

    // Arbitrary upstream activity while the stage is busy; all of it must be ignored.
    task automatic noise();
        EX_reg               = 7'($urandom);
        branch_conds_EX      = 5'($urandom);
        operation_result     = W'($urandom);
        data_wr_addr         = 16'($urandom);
        data_rd_addr         = 16'($urandom);
        destination_reg_addr = 3'($urandom);
        destination_RNS      = 1'($urandom);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".req"}, mem_req, 0);   chk({tag, ".we"}, mem_we, 0);
        chk({tag, ".addr"}, mem_addr, 0); chk({tag, ".wdata"}, mem_wdata, 0);
        chk({tag, ".stall"}, stall, 0);   chk({tag, ".rf_en"}, rf_wr_en, 0);
        chk({tag, ".rns_en"}, rns_rf_wr_en, 0); chk({tag, ".rf_addr"}, rf_wr_addr, 0);
        chk({tag, ".rf_data"}, rf_wr_data, 0);  chk({tag, ".carry"}, carry_flag, 0);
        chk({tag, ".fault"}, mem_fault, 0);
    endtask

    task automatic alu(input bit inv, input bit wr, input bit cout, input bit cin,
                       input bit rns, input logic [2:0] dest, input logic [W-1:0] res);
        bit w;
        EX_reg = exw(0, wr, cout, inv, 0);
        operation_result = res; destination_reg_addr = dest; destination_RNS = rns;
        set_bc(cin);
        #1 chk("alu.stall", stall, 0);
        tick();
        if (!inv && cout) carry_m = cin;
        EX_reg = exw(0, 0, 0, 1, 0);
        #1;
        w = !inv && wr;
        chk("alu.rf_en", rf_wr_en, w && !rns);
        chk("alu.rns_en", rns_rf_wr_en, w && rns);
        if (w) begin
            chk("alu.addr", rf_wr_addr, dest);
            chk("alu.data", rf_wr_data, rns ? res : W'(res[7:0]));
        end
        chk("alu.req", mem_req, 0);
        chk("alu.carry", carry_flag, carry_m);
    endtask

    task automatic store(input logic [15:0] addr, input logic [W-1:0] data, input int d,
                         input bit cout, input bit cin);
        EX_reg = exw(1, 0, cout, 0, 0);
        data_wr_addr = addr; data_rd_addr = ~addr; operation_result = data;
        set_bc(cin);
        #1 chk("st.stall0", stall, 1);
        chk("st.req0", mem_req, 0);
        tick();
        if (cout) carry_m = cin;
        for (int i = 0; i <= d; i++) begin
            noise();
            mem_ack = (i == d);
            #1;
            chk("st.req", mem_req, 1);    chk("st.we", mem_we, 1);
            chk("st.addr", mem_addr, addr); chk("st.wdata", mem_wdata, data);
            chk("st.stall", stall, 1);
            chk("st.wr", {rf_wr_en, rns_rf_wr_en}, 0);
            chk("st.carry", carry_flag, carry_m);
            tick();
        end
        mem_ack = 1'b0;
        EX_reg = exw(0, 0, 0, 1, 0);
        #1;
        chk("st.req_end", mem_req, 0);
        chk("st.stall_end", stall, 0);
        chk("st.wr_end", {rf_wr_en, rns_rf_wr_en}, 0);
        chk("st.fault", mem_fault, fault_m);
    endtask

    task automatic load(input logic [15:0] addr, input logic [W-1:0] rdata,
                        input logic [2:0] dest, input bit rns, input int d);
        EX_reg = exw(0, 1'($urandom), 0, 0, 1);
        data_rd_addr = addr; data_wr_addr = ~addr;
        destination_reg_addr = dest; destination_RNS = rns;
        #1 chk("ld.stall0", stall, 1);
        tick();
        for (int i = 0; i <= d; i++) begin
            noise();
            mem_ack   = (i == d);
            mem_rdata = (i == d) ? rdata : W'($urandom);
            #1;
            chk("ld.req", mem_req, 1);     chk("ld.we", mem_we, 0);
            chk("ld.addr", mem_addr, addr); chk("ld.stall", stall, 1);
            chk("ld.wr", {rf_wr_en, rns_rf_wr_en}, 0);
            tick();
        end
        mem_ack = 1'b0;
        mem_rdata = W'($urandom);
        noise();
        #1;
        chk("ld.wb_req", mem_req, 0);
        chk("ld.wb_stall", stall, 1);
        chk("ld.wb_rf_en", rf_wr_en, !rns);
        chk("ld.wb_rns_en", rns_rf_wr_en, rns);
        chk("ld.wb_addr", rf_wr_addr, dest);
        chk("ld.wb_data", rf_wr_data, rns ? rdata : W'(rdata[7:0]));
        tick();
        EX_reg = exw(0, 0, 0, 1, 0);
        #1;
        chk("ld.stall_end", stall, 0);
        chk("ld.wr_end", {rf_wr_en, rns_rf_wr_en}, 0);
        chk("ld.carry", carry_flag, carry_m);
    endtask

    task automatic timeout_store(input logic [15:0] addr);
        EX_reg = exw(1, 0, 0, 0, 0);
        data_wr_addr = addr; operation_result = W'($urandom);
        #1;
        tick();
        for (int i = 0; i < TO; i++) begin
            noise();
            mem_ack = 1'b0;
            #1;
            chk("to.req", mem_req, 1);
            chk("to.fault", mem_fault, fault_m);
            tick();
        end
        EX_reg = exw(0, 0, 0, 1, 0);
        fault_m = 1'b1;
        #1;
        chk("to.req_end", mem_req, 0);
        chk("to.fault_end", mem_fault, 1);
        chk("to.stall_end", stall, 0);
        chk("to.wr_end", {rf_wr_en, rns_rf_wr_en}, 0);
    endtask

    initial begin
        reset = 1'b1; EX_reg = exw(0, 0, 0, 1, 0);
        operation_result = '0; data_wr_addr = '0; data_rd_addr = '0;
        destination_reg_addr = '0; destination_RNS = 1'b0; branch_conds_EX = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        reset = 1'b0;
        #1 chk_zero("rst");

        // Reset held two cycles while a load is pending.
        EX_reg = exw(0, 0, 0, 0, 1); data_rd_addr = 16'h1234; destination_reg_addr = 3'd1;
        tick();
        EX_reg = exw(0, 0, 0, 1, 0);
        #1 chk("rstld.req_pending", mem_req, 1);
        reset = 1'b1;
        tick();
        #1 chk_zero("rstld1");
        tick();
        #1 chk_zero("rstld2");
        reset = 1'b0;

        alu(0, 1, 0, 0, 1, 3'd3, 16'h3A05);
        alu(0, 1, 0, 0, 0, 3'd6, 16'hBEEF);
        store(16'h0102, 16'h007E, 3, 0, 0);
        load(16'h0040, 16'h009C, 3'd5, 0, 0);
        load(16'h0041, 16'hA55A, 3'd2, 1, 2);

        alu(0, 0, 1, 0, 0, 3'd0, 16'h0000);
        alu(1, 0, 1, 1, 0, 3'd0, 16'h0000);
        EX_reg = exw(1, 0, 1, 1, 0); data_wr_addr = 16'h0200; set_bc(1'b1);
        #1 chk("inv_st.stall", stall, 0);
        tick();
        EX_reg = exw(0, 0, 0, 1, 0);
        #1 chk("inv_st.req", mem_req, 0);
        chk("inv_st.carry", carry_flag, carry_m);
        alu(0, 0, 1, 1, 0, 3'd0, 16'h0000);

        // Acknowledge outside an access must have no effect.
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1 chk("stray_ack.req", mem_req, 0);
        chk("stray_ack.wr", {rf_wr_en, rns_rf_wr_en}, 0);

        timeout_store(16'hCAFE);

        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 2))
                0: alu(1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), 3'($urandom), W'($urandom));
                1: store(16'($urandom), W'($urandom), $urandom_range(0, 5),
                         1'($urandom), 1'($urandom));
                default: load(16'($urandom), W'($urandom), 3'($urandom), 1'($urandom),
                              $urandom_range(0, 5));
            endcase
        end

        reset = 1'b1;
        EX_reg = exw(0, 0, 0, 1, 0);
        tick();
        reset = 1'b0;
        #1 chk_zero("final_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
